vga_image_loader: RTL and testbench

//   Writer side of the sprite image Block RAM. Takes RGB332 pixel bytes from the UART receiver and writes them

---
 rtl/vga_image_loader_if.sv | 23 ++
 rtl/vga_image_loader.sv | 124 ++++++++++++
 tb/tb_vga_image_loader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/vga_image_loader_if.sv
// vga_image_loader_if: UART byte stream in, BlockRam write port and load status out
interface vga_image_loader_if #(
  parameter int ADDR_BUS_SIZE = 9,
  parameter int ELEMENT_SIZE  = 8
);
  logic                     rx_dv;
  logic [7:0]               rx_byte;
  logic                     write_en;
  logic [ADDR_BUS_SIZE-1:0] write_addr;
  logic [ELEMENT_SIZE-1:0]  write_data;
  logic                     busy;
  logic                     done;
  logic                     error;
  logic [7:0]               load_count;
  modport master (
    output rx_dv, rx_byte,
    input  write_en, write_addr, write_data, busy, done, error, load_count
  );
  modport slave (
    input  rx_dv, rx_byte,
    output write_en, write_addr, write_data, busy, done, error, load_count
  );
endinterface

// File: rtl/vga_image_loader.sv
// vga_image_loader: writes a sync-framed RGB332 byte stream into the sprite BlockRam in raster order.
// Define CHECKSUM_EN to require a trailing mod-256 sum byte before a load counts as done.
module vga_image_loader #(
  parameter int         NUM_ELEMENTS   = 400,
  parameter int         ADDR_BUS_SIZE  = 9,
  parameter int         ELEMENT_SIZE   = 8,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 2_500_000
) (
  input logic              i_CLK,
  input logic              i_RST_L,
  vga_image_loader_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
`ifdef CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD} state_t;
`endif
  state_t                   state, state_nx;
  logic [ADDR_BUS_SIZE-1:0] pix, pix_nx, addr_nx;
  logic [TW-1:0]            tmo, tmo_nx;
  logic [ELEMENT_SIZE-1:0]  data_nx;
  logic [7:0]               cnt_nx;
  logic                     we_nx, done_nx, err_nx, tmo_hit, last;
`ifdef CHECKSUM_EN
  logic [7:0]               sum, sum_nx;
`endif
  assign tmo_hit = !bus.rx_dv && tmo == TW'(TIMEOUT_CYCLES - 1);
  assign last    = pix == ADDR_BUS_SIZE'(NUM_ELEMENTS - 1);
  always_comb begin
    state_nx = state;
    pix_nx   = pix;
    tmo_nx   = &tmo ? tmo : tmo + 1'b1;
    addr_nx  = bus.write_addr;
    data_nx  = bus.write_data;
    cnt_nx   = bus.load_count;
    we_nx    = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
`ifdef CHECKSUM_EN
    sum_nx   = sum;
`endif
    case (state)
      IDLE: begin
        tmo_nx = '0;
        if (bus.rx_dv && bus.rx_byte == SYNC_BYTE) begin
          state_nx = LOAD;
          pix_nx   = '0;
`ifdef CHECKSUM_EN
          sum_nx   = '0;
`endif
        end
      end
      LOAD: begin
        if (bus.rx_dv) begin
          we_nx   = 1'b1;
          addr_nx = pix;
          data_nx = bus.rx_byte;
          pix_nx  = pix + 1'b1;
          tmo_nx  = '0;
`ifdef CHECKSUM_EN
          sum_nx  = sum + bus.rx_byte;
          if (last) state_nx = CHECK;
`else
          if (last) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
            cnt_nx   = bus.load_count + 1'b1;
          end
`endif
        end else if (tmo_hit) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end
      end
`ifdef CHECKSUM_EN
      CHECK: begin
        if (bus.rx_dv) begin
          state_nx = IDLE;
          done_nx  = bus.rx_byte == sum;
          err_nx   = bus.rx_byte != sum;
          cnt_nx   = bus.rx_byte == sum ? bus.load_count + 1'b1 : bus.load_count;
        end else if (tmo_hit) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_CLK or negedge i_RST_L) begin
    if (!i_RST_L) begin
      state          <= IDLE;
      pix            <= '0;
      tmo            <= '0;
      bus.write_en   <= 1'b0;
      bus.write_addr <= '0;
      bus.write_data <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;
      bus.load_count <= '0;
    end else begin
      state          <= state_nx;
      pix            <= pix_nx;
      tmo            <= tmo_nx;
      bus.write_en   <= we_nx;
      bus.write_addr <= addr_nx;
      bus.write_data <= data_nx;
      bus.busy       <= state_nx != IDLE;
      bus.done       <= done_nx;
      bus.error      <= err_nx;
      bus.load_count <= cnt_nx;
    end
  end
`ifdef CHECKSUM_EN
  always_ff @(posedge i_CLK or negedge i_RST_L) begin
    if (!i_RST_L) sum <= '0;
    else sum <= sum_nx;
  end
`endif
endmodule

// File: tb/tb_vga_image_loader.sv
// tb_vga_image_loader: directed loads, idle filtering, timeout, in-band sync byte and mid-load reset.
module tb_vga_image_loader;
  logic i_CLK = 1'b0;
  logic i_RST_L = 1'b1;
  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic prev_we = 1'b0;
  logic [7:0] mem [0:511];
  vga_image_loader_if bus ();
  vga_image_loader #(.TIMEOUT_CYCLES(1000)) dut (.i_CLK(i_CLK), .i_RST_L(i_RST_L), .bus(bus));
  always #5 i_CLK = ~i_CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] pat(input int p, input int i);
    return p == 0 ? 8'(i) : p == 1 ? (i == 5 ? 8'hA5 : 8'(i * 3 + 1)) : 8'h01;
  endfunction
  function automatic logic [7:0] sum_of(input int p);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 400; i++) s = s + pat(p, i);
    return s;
  endfunction
  always @(negedge i_CLK) begin
    if (prev_we) check("we_gap", {31'd0, bus.write_en}, 0);
    if (bus.write_en) begin
      mem[bus.write_addr] = bus.write_data;
      wr_cnt++;
    end
    if (bus.done) begin
      done_cnt++;
      check("done_err_excl", {31'd0, bus.error}, 0);
`ifdef CHECKSUM_EN
      check("done_no_write", {31'd0, bus.write_en}, 0);
`else
      check("done_last_write", {22'd0, bus.write_en, bus.write_addr}, {22'd0, 1'b1, 9'd399});
`endif
    end
    if (bus.error) err_cnt++;
    prev_we = bus.write_en;
  end
  task automatic send(input logic [7:0] b, input int gap = 2);
    @(negedge i_CLK);
    bus.rx_dv = 1'b1;
    bus.rx_byte = b;
    @(negedge i_CLK);
    bus.rx_dv = 1'b0;
    repeat (gap) @(negedge i_CLK);
  endtask
  task automatic load(input int p, input int n = 400);
    send(8'hA5);
    for (int i = 0; i < n; i++) send(pat(p, i));
  endtask
  task automatic verify(input string tag, input int p, input int wr0, input int dn0, input int er0,
                        input int cnt);
    repeat (3) @(negedge i_CLK);
    check({tag, "_writes"}, wr_cnt - wr0, 400);
    check({tag, "_done"}, done_cnt - dn0, 1);
    check({tag, "_err"}, err_cnt - er0, 0);
    check({tag, "_count"}, {24'd0, bus.load_count}, cnt);
    check({tag, "_busy"}, {31'd0, bus.busy}, 0);
    for (int i = 0; i < 400; i++) check({tag, "_mem"}, {24'd0, mem[i]}, {24'd0, pat(p, i)});
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_we"}, {31'd0, bus.write_en}, 0);
    check({tag, "_addr"}, {23'd0, bus.write_addr}, 0);
    check({tag, "_data"}, {24'd0, bus.write_data}, 0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 0);
    check({tag, "_done"}, {31'd0, bus.done}, 0);
    check({tag, "_error"}, {31'd0, bus.error}, 0);
    check({tag, "_count"}, {24'd0, bus.load_count}, 0);
  endtask
  initial begin
    int wr0, dn0, er0, n;
    bus.rx_dv = 1'b0;
    bus.rx_byte = 8'h00;
    #1 i_RST_L = 1'b0;
    repeat (3) @(negedge i_CLK);
    check_zero("reset");
    i_RST_L = 1'b1;
    wr0 = wr_cnt; dn0 = done_cnt; er0 = err_cnt;
    load(0);
`ifdef CHECKSUM_EN
    send(sum_of(0));
`endif
    verify("ramp", 0, wr0, dn0, er0, 1);
    wr0 = wr_cnt;
    send(8'h00); check("idle_00_busy", {31'd0, bus.busy}, 0);
    send(8'hFF); check("idle_ff_busy", {31'd0, bus.busy}, 0);
    send(8'h3C); check("idle_3c_busy", {31'd0, bus.busy}, 0);
    check("idle_writes", wr_cnt - wr0, 0);
    check("idle_count", {24'd0, bus.load_count}, 1);
    send(8'hA5, 0);
    check("sync_busy", {31'd0, bus.busy}, 1);
    wr0 = wr_cnt; dn0 = done_cnt; er0 = err_cnt;
    for (int i = 0; i < 10; i++) send(8'h10 + 8'(i));
    n = 0;
    while (!bus.error && n < 1100) begin
      @(negedge i_CLK);
      n++;
    end
    check("tmo_latency", n, 998);
    check("tmo_busy", {31'd0, bus.busy}, 0);
    check("tmo_last_addr", {23'd0, bus.write_addr}, 9);
    check("tmo_last_data", {24'd0, bus.write_data}, 8'h19);
    check("tmo_writes", wr_cnt - wr0, 10);
    check("tmo_no_done", done_cnt - dn0, 0);
    @(negedge i_CLK);
    check("tmo_pulse", {31'd0, bus.error}, 0);
    check("tmo_err_once", err_cnt - er0, 1);
    repeat (20) @(negedge i_CLK);
    check("tmo_no_late_writes", wr_cnt - wr0, 10);
    wr0 = wr_cnt; dn0 = done_cnt; er0 = err_cnt;
    load(1);
`ifdef CHECKSUM_EN
    send(sum_of(1));
`endif
    verify("inband_sync", 1, wr0, dn0, er0, 2);
    check("inband_a5", {24'd0, mem[5]}, 8'hA5);
    wr0 = wr_cnt; er0 = err_cnt;
    load(0, 200);
    check("pre_rst_busy", {31'd0, bus.busy}, 1);
    #2 i_RST_L = 1'b0;
    #1 check_zero("async_rst");
    check("rst_writes", wr_cnt - wr0, 200);
    repeat (3) @(negedge i_CLK);
    check("rst_no_err", err_cnt - er0, 0);
    i_RST_L = 1'b1;
    wr0 = wr_cnt; dn0 = done_cnt; er0 = err_cnt;
    load(0);
`ifdef CHECKSUM_EN
    send(sum_of(0));
`endif
    verify("after_rst", 0, wr0, dn0, er0, 1);
`ifdef CHECKSUM_EN
    wr0 = wr_cnt; dn0 = done_cnt; er0 = err_cnt;
    load(2);
    send(8'h90);
    verify("csum_ok", 2, wr0, dn0, er0, 2);
    wr0 = wr_cnt; dn0 = done_cnt; er0 = err_cnt;
    load(2);
    send(8'h91);
    repeat (3) @(negedge i_CLK);
    check("csum_bad_err", err_cnt - er0, 1);
    check("csum_bad_done", done_cnt - dn0, 0);
    check("csum_bad_count", {24'd0, bus.load_count}, 2);
    check("csum_bad_writes", wr_cnt - wr0, 400);
    check("csum_bad_busy", {31'd0, bus.busy}, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
